// File: rtl/alu_pkg.sv
// ALU operation codes and instruction-field constants shared by the issue front end
// (and, later, by the ALU itself).
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_ILLEGAL = 4'b0011,
    ALU_XOR     = 4'b0101,
    ALU_SUB     = 4'b0110,
    ALU_SLL     = 4'b0111,
    ALU_EQ      = 4'b1000,
    ALU_SLT     = 4'b1100,
    ALU_SRA     = 4'b1110,
    ALU_SRL     = 4'b1111
  } alu_op_e;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of ALUOp/funct3/funct7 into the 4-bit ALU operation code.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_e    operation,
  output logic       illegal
);

  logic is_rtype;
  logic f7_base;
  logic f7_alt;
  logic f7_ok;

  assign is_rtype = (aluop == ALUOP_RTYPE);
  assign f7_base  = (funct7 == F7_BASE);
  assign f7_alt   = (funct7 == F7_ALT);
  // I-type immediates occupy funct7 for these codes, so only R-type must match
  assign f7_ok    = !is_rtype || f7_base;

  always_comb begin
    // NOTE: default assigned first so every path drives the output; no latch is inferred.
    operation = ALU_ILLEGAL;
    case (aluop)
      ALUOP_ADD:    operation = ALU_ADD;
      ALUOP_BRANCH: operation = ALU_EQ;
      default: begin
        case (funct3)
          3'b000: begin
            if (f7_ok)       operation = ALU_ADD;
            else if (f7_alt) operation = ALU_SUB;
          end
          3'b001: if (f7_base) operation = ALU_SLL;
          3'b010: if (f7_ok)   operation = ALU_SLT;
          3'b100: if (f7_ok)   operation = ALU_XOR;
          3'b101: begin
            if (f7_base)     operation = ALU_SRL;
            else if (f7_alt) operation = ALU_SRA;
          end
          3'b110: if (f7_ok)   operation = ALU_OR;
          3'b111: if (f7_ok)   operation = ALU_AND;
          default:             operation = ALU_ILLEGAL;
        endcase
      end
    endcase
    illegal = (operation == ALU_ILLEGAL);
  end

endmodule

// File: rtl/alu_issue.sv
// Two-stage valid/ready front end for the combinational ALU: S1 drives the ALU
// inputs, S2 captures the result with its tag for the writeback side.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int TAG_WIDTH     = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_aluop,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [DATA_WIDTH-1:0]    in_src_a,
  input  logic [DATA_WIDTH-1:0]    in_src_b,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic [DATA_WIDTH-1:0]    alu_src_a,
  output logic [DATA_WIDTH-1:0]    alu_src_b,
  output logic [OPCODE_LENGTH-1:0] alu_operation,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_result,
  output logic [TAG_WIDTH-1:0]     out_tag,
  output logic                     out_illegal
);

  alu_op_e dec_op;
  logic    dec_illegal;

  alu_op_decode u_decode (
    .aluop     (in_aluop),
    .funct3    (in_funct3),
    .funct7    (in_funct7),
    .operation (dec_op),
    .illegal   (dec_illegal)
  );

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_src_a;
  logic [DATA_WIDTH-1:0] s1_src_b;
  alu_op_e               s1_op;
  logic [TAG_WIDTH-1:0]  s1_tag;
  logic                  s1_illegal;

  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_result;
  logic [TAG_WIDTH-1:0]  s2_tag;
  logic                  s2_illegal;

  logic s1_adv;
  logic s2_adv;
  logic accept;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  // flush deliberately does not gate in_ready; the request is dropped instead
  assign in_ready = s1_adv && reset;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: payload fields are cleared too, because the ALU and writeback ports are observable in reset.
      s1_valid   <= 1'b0;
      s1_src_a   <= '0;
      s1_src_b   <= '0;
      s1_op      <= ALU_AND;
      s1_tag     <= '0;
      s1_illegal <= 1'b0;
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_tag     <= '0;
      s2_illegal <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let S2 capture the S1 value from before this edge.
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_result  <= s1_illegal ? '0 : alu_result;
          s2_tag     <= s1_tag;
          s2_illegal <= s1_illegal;
        end
      end
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_src_a   <= in_src_a;
          s1_src_b   <= in_src_b;
          s1_op      <= dec_op;
          s1_tag     <= in_tag;
          s1_illegal <= dec_illegal;
        end
      end
    end
  end

  assign alu_src_a     = s1_src_a;
  assign alu_src_b     = s1_src_b;
  assign alu_operation = OPCODE_LENGTH'(s1_op);

  assign out_valid   = s2_valid;
  assign out_result  = s2_result;
  assign out_tag     = s2_tag;
  assign out_illegal = s2_illegal;

endmodule
